sram_read_arbiter: RTL

//  Shares the SRAM read port between NUM_CLIENTS fabric clients. Arbitrates

---
 rtl/sram_read_arbiter_if.sv | 27 ++
 rtl/sram_read_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/sram_read_arbiter_if.sv
// sram_read_arbiter_if: client request, SRAM read and demux tag signals of the SRAM read arbiter
interface sram_read_arbiter_if #(
  parameter int NUM_CLIENTS = 16,
  parameter int ADDR_W = 19,
  parameter int CID_W = $clog2(NUM_CLIENTS)
);
  logic [NUM_CLIENTS-1:0] client_read_req;
  logic [NUM_CLIENTS*ADDR_W-1:0] client_read_addr;
  logic [4:0] client_priority;
  logic sram_rd_ready;
  logic [NUM_CLIENTS-1:0] client_grant;
  logic sram_rd_en;
  logic [ADDR_W-1:0] sram_rd_addr;
  logic demux_valid;
  logic [CID_W-1:0] demux_client;
  logic [ADDR_W-1:0] demux_base_addr;
  logic demux_last;
  logic busy;
  modport master (
    output client_read_req, client_read_addr, client_priority, sram_rd_ready,
    input client_grant, sram_rd_en, sram_rd_addr, demux_valid, demux_client, demux_base_addr, demux_last, busy
  );
  modport slave (
    input client_read_req, client_read_addr, client_priority, sram_rd_ready,
    output client_grant, sram_rd_en, sram_rd_addr, demux_valid, demux_client, demux_base_addr, demux_last, busy
  );
endinterface

// File: rtl/sram_read_arbiter.sv
// sram_read_arbiter: round-robin SRAM read-port arbiter issuing tagged fixed-length read bursts
module sram_read_arbiter #(
  parameter int NUM_CLIENTS = 16,
  parameter int ADDR_W = 19,
  parameter int BURST_LEN = 4,
  parameter int SRAM_LAT = 2
) (
  input logic clk,
  input logic rst,
  sram_read_arbiter_if.slave bus
);
  localparam int CID_W = $clog2(NUM_CLIENTS);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nx;
  logic [CID_W-1:0] ptr, win, cid, idx;
  logic [ADDR_W-1:0] base;
  logic [BW-1:0] beat;
  logic [NUM_CLIENTS-1:0] grant;
  logic any, ovr, fire, fin;
  logic [SRAM_LAT-1:0] p_v, p_l;
  logic [CID_W-1:0] p_c [SRAM_LAT];
  logic [ADDR_W-1:0] p_b [SRAM_LAT];
  int s;

  // descending scan so the first requester at/after ptr is the last one written
  always_comb begin
    any = |bus.client_read_req;
    ovr = bus.client_priority[4] && bus.client_read_req[bus.client_priority[3:0]];
    win = '0;
    s = 0;
    idx = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      s = int'(ptr) + i;
      s = s >= NUM_CLIENTS ? s - NUM_CLIENTS : s;
      idx = CID_W'(s);
      if (bus.client_read_req[idx]) win = idx;
    end
    if (ovr) win = CID_W'(bus.client_priority[3:0]);
  end

  assign fire = state == ISSUE && bus.sram_rd_ready;
  assign fin = fire && beat == BW'(BURST_LEN - 1);

  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (any ? ISSUE : IDLE) :
               state == ISSUE ? (fin ? DRAIN : ISSUE) :
               (p_v[SRAM_LAT-1] && p_l[SRAM_LAT-1] ? IDLE : DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cid <= '0;
      base <= '0;
      beat <= '0;
      grant <= '0;
    end else begin
      state <= state_nx;
      grant <= '0;
      if (state == IDLE && any) begin
        cid <= win;
        base <= bus.client_read_addr[win*ADDR_W +: ADDR_W];
        grant <= NUM_CLIENTS'(1) << win;
        beat <= '0;
        if (!ovr) ptr <= win == CID_W'(NUM_CLIENTS - 1) ? '0 : win + 1'b1;
      end
      if (fire) beat <= fin ? '0 : beat + 1'b1;
    end
  end

  // tag pipe mirrors SRAM latency; tags only advance with a valid word so the output holds
  always_ff @(posedge clk) begin
    if (rst) begin
      p_v <= '0;
      p_l <= '0;
      for (int k = 0; k < SRAM_LAT; k++) begin
        p_c[k] <= '0;
        p_b[k] <= '0;
      end
    end else begin
      p_v[0] <= fire;
      p_l[0] <= fin;
      if (fire) begin
        p_c[0] <= cid;
        p_b[0] <= base;
      end
      for (int k = 1; k < SRAM_LAT; k++) begin
        p_v[k] <= p_v[k-1];
        p_l[k] <= p_l[k-1];
        if (p_v[k-1]) begin
          p_c[k] <= p_c[k-1];
          p_b[k] <= p_b[k-1];
        end
      end
    end
  end

  assign bus.client_grant = grant;
  assign bus.sram_rd_en = fire;
  assign bus.sram_rd_addr = state == ISSUE ? base + ADDR_W'(beat) : '0;
  assign bus.demux_valid = p_v[SRAM_LAT-1];
  assign bus.demux_last = p_v[SRAM_LAT-1] && p_l[SRAM_LAT-1];
  assign bus.demux_client = p_c[SRAM_LAT-1];
  assign bus.demux_base_addr = p_b[SRAM_LAT-1];
  assign bus.busy = state != IDLE;
endmodule
